// File: rtl/sprite_motion_sched.sv
// sprite_motion_sched: bouncing-sprite motion scheduler with host repositioning and priority compositing.
// Optional macro SPRITE_OVERRUN_CNT_EN adds an 8-bit saturating count of collapsed frame pulses.
module sprite_motion_sched #(
    parameter int WIDTH = 800,
    parameter int HEIGHT = 600,
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_SIZE = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic [$clog2(WIDTH)-1:0] x,
    input  logic [$clog2(HEIGHT)-1:0] y,
    input  logic frame,
    input  logic cfg_valid,
    output logic cfg_ready,
    input  logic [2:0] cfg_idx,
    input  logic [$clog2(WIDTH)-1:0] cfg_x,
    input  logic [$clog2(HEIGHT)-1:0] cfg_y,
    output logic busy,
    output logic [23:0] data
`ifdef SPRITE_OVERRUN_CNT_EN
    ,
    output logic [7:0] overrun_cnt
`endif
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] XMAX = XW'(WIDTH - SPRITE_SIZE);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - SPRITE_SIZE);
    localparam logic [2:0] LAST = 3'(NUM_SPRITES - 1);

    typedef enum logic {IDLE, UPDATE} state_t;
    state_t state, state_nx;
    logic [2:0] ptr, ptr_nx;
    logic pending, pending_nx;
    logic [XW-1:0] sx [NUM_SPRITES];
    logic [YW-1:0] sy [NUM_SPRITES];
    logic dx [NUM_SPRITES];
    logic dy [NUM_SPRITES];
    logic [1:0] col [NUM_SPRITES];
    logic [XW-1:0] cur_x, nxt_x;
    logic [YW-1:0] cur_y, nxt_y;
    logic cur_dx, cur_dy, flip_x, flip_y;
    logic cfg_acc;

    function automatic logic [23:0] palette(input logic [1:0] c);
        return c == 2'd0 ? 24'h012345 : c == 2'd1 ? 24'hFF0000 : c == 2'd2 ? 24'h00FF00 : 24'h0000FF;
    endfunction

    assign busy = state == UPDATE;
    assign cfg_ready = state == IDLE;
    assign cfg_acc = cfg_valid && cfg_ready;

    // a frame arriving on the last cycle of a pass is folded into the restart decision
    always_comb begin
        state_nx = state;
        ptr_nx = ptr;
        pending_nx = pending;
        if (state == IDLE) begin
            state_nx = frame ? UPDATE : IDLE;
            ptr_nx = '0;
        end else begin
            ptr_nx = ptr == LAST ? '0 : ptr + 3'd1;
            pending_nx = ptr == LAST ? 1'b0 : pending | frame;
            state_nx = (ptr == LAST && !(pending || frame)) ? IDLE : UPDATE;
        end
    end

    // single shared motion datapath, muxed onto the sprite selected by ptr
    always_comb begin
        cur_x = '0;
        cur_y = '0;
        cur_dx = 1'b0;
        cur_dy = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++)
            if (ptr == 3'(i)) begin
                cur_x = sx[i];
                cur_y = sy[i];
                cur_dx = dx[i];
                cur_dy = dy[i];
            end
        flip_x = cur_dx ? cur_x >= XMAX : cur_x == '0;
        flip_y = cur_dy ? cur_y >= YMAX : cur_y == '0;
        nxt_x = flip_x ? cur_x : cur_dx ? cur_x + XW'(1) : cur_x - XW'(1);
        nxt_y = flip_y ? cur_y : cur_dy ? cur_y + YW'(1) : cur_y - YW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            pending <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sx[i] <= XW'(i * SPRITE_SIZE);
                sy[i] <= YW'(i * SPRITE_SIZE);
                dx[i] <= 1'b1;
                dy[i] <= 1'b1;
                col[i] <= 2'(i % 4);
            end
        end else begin
            state <= state_nx;
            ptr <= ptr_nx;
            pending <= pending_nx;
            for (int i = 0; i < NUM_SPRITES; i++)
                if (cfg_acc && cfg_idx == 3'(i)) begin
                    sx[i] <= cfg_x > XMAX ? XMAX : cfg_x;
                    sy[i] <= cfg_y > YMAX ? YMAX : cfg_y;
                end else if (busy && ptr == 3'(i)) begin
                    sx[i] <= nxt_x;
                    sy[i] <= nxt_y;
                    dx[i] <= dx[i] ^ flip_x;
                    dy[i] <= dy[i] ^ flip_y;
                    col[i] <= col[i] + 2'(flip_x | flip_y);
                end
        end
    end

    // scan from the highest index down so the lowest covering sprite wins
    always_comb begin
        data = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--)
            if ({1'b0, x} >= {1'b0, sx[i]} && {1'b0, x} < {1'b0, sx[i]} + (XW+1)'(SPRITE_SIZE) &&
                {1'b0, y} >= {1'b0, sy[i]} && {1'b0, y} < {1'b0, sy[i]} + (YW+1)'(SPRITE_SIZE))
                data = palette(col[i]);
    end

`ifdef SPRITE_OVERRUN_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overrun_cnt <= '0;
        else if (cfg_acc && cfg_idx == 3'd7)
            overrun_cnt <= '0;
        else if (busy && frame && pending && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_sprite_motion_sched.sv
// tb_sprite_motion_sched: randomized scoreboard bench for sprite_motion_sched against a per-sprite reference model.
// Build with SPRITE_OVERRUN_CNT_EN to also check overrun_cnt.
module tb_sprite_motion_sched;
    localparam int W = 800, H = 600, N = 4, S = 100;
    localparam int XMAX = W - S, YMAX = H - S;

    logic clk = 1'b0, reset = 1'b1;
    logic [9:0] x = '0, y = '0;
    logic frame = 1'b0, cfg_valid = 1'b0;
    logic cfg_ready, busy;
    logic [2:0] cfg_idx = '0;
    logic [9:0] cfg_x = '0, cfg_y = '0;
    logic [23:0] data;
`ifdef SPRITE_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt;
    int exp_ovr = 0;
`endif

    always #5 clk = ~clk;

    sprite_motion_sched #(.WIDTH(W), .HEIGHT(H), .NUM_SPRITES(N), .SPRITE_SIZE(S)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .frame(frame),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .busy(busy), .data(data)
`ifdef SPRITE_OVERRUN_CNT_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    typedef struct {int cyc; int kind; logic [23:0] exp;} probe_t;
    probe_t q[$];
    int cyc = 0, n_chk = 0, n_pass = 0;
    int pin_x = -1, pin_y = -1;
    int mx[N], my[N], mc[N];
    bit mdx[N], mdy[N];
    logic [23:0] pal[4] = '{24'h012345, 24'hFF0000, 24'h00FF00, 24'h0000FF};
    logic [23:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        return k == 0 ? "pixel" : k == 1 ? "busy" : k == 2 ? "cfg_ready" : "overrun_cnt";
    endfunction

    // scoreboard monitor: compares every expectation scheduled for this cycle
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].cyc == cyc) begin
                act = '0;
                case (q[i].kind)
                    0: act = data;
                    1: act = {23'b0, busy};
                    2: act = {23'b0, cfg_ready};
`ifdef SPRITE_OVERRUN_CNT_EN
                    3: act = {16'b0, overrun_cnt};
`endif
                    default: act = '0;
                endcase
                n_chk++;
                if (act === q[i].exp) n_pass++;
                else $display("FAIL %s cyc=%0d x=%0d y=%0d got=%h expected=%h", kname(q[i].kind), cyc, x, y, act, q[i].exp);
                q.delete(i);
            end
    end

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = i * S; my[i] = i * S; mdx[i] = 1; mdy[i] = 1; mc[i] = i % 4;
        end
    endfunction

    function automatic void model_step(int i);
        bit fl = 0;
        if (mdx[i]) begin if (mx[i] < XMAX) mx[i]++; else begin mdx[i] = 0; fl = 1; end end
        else begin if (mx[i] > 0) mx[i]--; else begin mdx[i] = 1; fl = 1; end end
        if (mdy[i]) begin if (my[i] < YMAX) my[i]++; else begin mdy[i] = 0; fl = 1; end end
        else begin if (my[i] > 0) my[i]--; else begin mdy[i] = 1; fl = 1; end end
        if (fl) mc[i] = (mc[i] + 1) % 4;
    endfunction

    function automatic void model_cfg(int idx, int cx, int cy);
        if (idx < N) begin
            mx[idx] = cx > XMAX ? XMAX : cx;
            my[idx] = cy > YMAX ? YMAX : cy;
        end
`ifdef SPRITE_OVERRUN_CNT_EN
        if (idx == 7) exp_ovr = 0;
`endif
    endfunction

    function automatic logic [23:0] exp_pixel(int px, int py);
        for (int i = 0; i < N; i++)
            if (px >= mx[i] && px < mx[i] + S && py >= my[i] && py < my[i] + S) return pal[mc[i]];
        return 24'h000000;
    endfunction

    task automatic push(int k, logic [23:0] e);
        q.push_back('{cyc, k, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(int px, int py);
        x = 10'(px);
        y = 10'(py);
        push(0, exp_pixel(px, py));
    endtask

    // random pixel biased to land near a sprite edge, or the pinned pixel
    task automatic pix_rand();
        int k, px, py;
        if (pin_x >= 0) begin pix(pin_x, pin_y); return; end
        k = $urandom_range(N - 1);
        px = mx[k] + int'($urandom_range(S + 3)) - 2;
        py = my[k] + int'($urandom_range(S + 3)) - 2;
        px = px < 0 ? 0 : px > W - 1 ? W - 1 : px;
        py = py < 0 ? 0 : py > H - 1 ? H - 1 : py;
        pix(px, py);
    endtask

    task automatic ctrl(bit b);
        push(1, {23'b0, b});
        push(2, {23'b0, ~b});
    endtask

    task automatic probe_sprites(int nrand);
        int px, py;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 5; k++) begin
                px = k == 1 ? mx[i] + S - 1 : k == 2 ? mx[i] + S : k == 3 ? mx[i] - 1 : mx[i];
                py = k == 1 || k == 3 ? my[i] + S - 1 : k == 4 ? my[i] + S : my[i];
                if (px >= 0 && px < W && py >= 0 && py < H) begin pix(px, py); tick(); end
            end
        repeat (nrand) begin pix_rand(); tick(); end
    endtask

    task automatic cfg_write(int idx, int cx, int cy);
        cfg_valid = 1; cfg_idx = 3'(idx); cfg_x = 10'(cx); cfg_y = 10'(cy);
        push(2, 24'd1);
        tick();
        model_cfg(idx, cx, cy);
        cfg_valid = 0;
    endtask

    // mode 0: plain frame; 1: cfg write in the same cycle as frame; 2: cfg held through the pass
    task automatic do_frame(int extra, int mode, int ci, int cx, int cy);
        int p;
        p = extra > 0 ? 2 : 1;
        frame = 1;
        ctrl(0);
        pix_rand();
        if (mode == 1) begin cfg_valid = 1; cfg_idx = 3'(ci); cfg_x = 10'(cx); cfg_y = 10'(cy); end
        tick();
        frame = 0;
        if (mode == 1) begin model_cfg(ci, cx, cy); cfg_valid = 0; end
        for (int j = 0; j < p * N; j++) begin
            frame = j >= 1 && j <= extra;
            if (mode == 2 && j == 0) begin cfg_valid = 1; cfg_idx = 3'(ci); cfg_x = 10'(cx); cfg_y = 10'(cy); end
            ctrl(1);
            pix_rand();
            tick();
            model_step(j % N);
        end
        frame = 0;
        ctrl(0);
        pix_rand();
`ifdef SPRITE_OVERRUN_CNT_EN
        exp_ovr = exp_ovr + (extra > 1 ? extra - 1 : 0);
        if (exp_ovr > 255) exp_ovr = 255;
        push(3, 24'(exp_ovr));
`endif
        if (mode == 2) begin tick(); model_cfg(ci, cx, cy); cfg_valid = 0; end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) tick();
        reset = 0;
        ctrl(0); pix(0, 0); tick();
        pix(150, 150); tick();
        pix(799, 599); tick();

        pin_x = 0; pin_y = 0;
        do_frame(0, 0, 0, 0, 0);
        pin_x = -1;
        probe_sprites(2);

        cfg_write(0, 750, 20);
        do_frame(0, 0, 0, 0, 0);
        pix(700, 21); tick();
        probe_sprites(0);

        frame = 1; tick(); frame = 0; tick(); tick();
        #1 reset = 1;
        model_reset();
`ifdef SPRITE_OVERRUN_CNT_EN
        exp_ovr = 0;
        push(3, 24'd0);
`endif
        ctrl(0); pix(0, 0); tick();
        ctrl(0); pix(0, 0); tick();
        reset = 0;
        probe_sprites(0);

        do_frame(0, 1, 0, 700, 500);
        pix(700, 500); tick();
        do_frame(3, 0, 0, 0, 0);
        probe_sprites(0);

        cfg_write(1, 200, 200);
        cfg_write(2, 220, 220);
        pix(250, 250); tick();
        do_frame(1, 2, 3, 1000, 1000);
        probe_sprites(1);

        repeat (25) begin
            case ($urandom_range(3))
                0: do_frame($urandom_range(3), 0, 0, 0, 0);
                1: cfg_write($urandom_range(7), $urandom_range(1023), $urandom_range(1023));
                2: do_frame($urandom_range(3), 1 + $urandom_range(1), $urandom_range(7), $urandom_range(1023), $urandom_range(1023));
                default: probe_sprites(3);
            endcase
        end
        probe_sprites(4);
`ifdef SPRITE_OVERRUN_CNT_EN
        cfg_write(7, 0, 0);
        push(3, 24'd0); tick();
`endif
        repeat (3) tick();
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got=%0d expected=0 pending expectations", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sprite_motion_sched.md
Name: sprite_motion_sched

Overview:
- Owns position, direction and colour state for NUM_SPRITES bouncing square sprites on the VGA raster.
- On each frame pulse it time-shares one motion-update datapath across all sprites, one sprite per clock.
- Accepts host repositioning writes over a valid/ready handshake.
- Per pixel, composites the sprites by fixed priority into the 24-bit RGB stream consumed by the VGA output stage.

Parameters:
- WIDTH, 800, active pixels per line.
- HEIGHT, 600, active lines per frame.
- NUM_SPRITES, 4, number of sprites, 1..8.
- SPRITE_SIZE, 100, sprite edge length in pixels.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  reset.
- x  in  $clog2(WIDTH)  current pixel column.
- y  in  $clog2(HEIGHT)  current pixel row.
- frame  in  1  one-cycle pulse per frame.
- cfg_valid  in  1  host write request.
- cfg_ready  out  1  write can be accepted.
- cfg_idx  in  3  target sprite index.
- cfg_x  in  $clog2(WIDTH)  new column.
- cfg_y  in  $clog2(HEIGHT)  new row.
- busy  out  1  motion update in progress.
- data  out  24  composited RGB pixel.

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- Palette, index 0..3: 24'h012345, 24'hFF0000, 24'h00FF00, 24'h0000FF. Colour index advances modulo 4.
- Limits: XMAX = WIDTH-SPRITE_SIZE, YMAX = HEIGHT-SPRITE_SIZE.
- Reset values, sprite i: x = y = i*SPRITE_SIZE; dir_x = dir_y = 1; colour = i mod 4.
- Reset values, controller: state IDLE, pending = 0, busy = 0, cfg_ready = 1.
- FSM states:
  - IDLE: frame=1 -> UPDATE with ptr = 0.
  - UPDATE: each cycle updates sprite[ptr], then ptr++. After ptr = NUM_SPRITES-1: if pending, clear pending and stay in UPDATE with ptr = 0; else go to IDLE.
- Timing: busy = (state==UPDATE) and is registered. A frame pulse at cycle t in IDLE raises busy from t+1. Sprite k registers change at the edge ending cycle t+1+k. busy is low again at t+1+NUM_SPRITES.
- Motion rule, per axis, x shown (y identical with YMAX):
  - dir=1 and x<XMAX: x+1. dir=1 and x>=XMAX: flip dir, x unchanged.
  - dir=0 and x>0: x-1. dir=0 and x==0: flip dir, x unchanged.
  - Colour advances by exactly one when either or both axes flip in the same update.
- Frame pulse in UPDATE: sets pending. Multiple pulses during one pass collapse to one.
- cfg handshake:
  - cfg_ready = (state==IDLE).
  - Write accepted when cfg_valid && cfg_ready.
  - Sprite[cfg_idx] x and y load the clamped values min(cfg_x, XMAX) and min(cfg_y, YMAX); dir and colour are unchanged.
  - cfg_idx >= NUM_SPRITES: accepted and ignored.
  - cfg_valid may be held across UPDATE; it is accepted on the first IDLE cycle.
- Simultaneous cfg accept and frame in IDLE: the write commits this edge; the update pass starts next cycle and uses the written values.
- Compositing (combinational):
  - A sprite covers a pixel if x in [sx, sx+SPRITE_SIZE) and y in [sy, sy+SPRITE_SIZE).
  - The lowest-index covering sprite supplies data = palette[colour]; no coverage gives 24'h000000.
  - Coordinate compares use $clog2(WIDTH)+1 / $clog2(HEIGHT)+1 bits so there is no wrap.
- Reset asserted mid-pass: all state returns immediately to the reset values; pending is cleared.

Optional Feature:
- Macro: SPRITE_OVERRUN_CNT_EN.
- Defined:
  - Adds output port overrun_cnt (8 bits).
  - Increments, saturating at 255, on every frame pulse that arrives while pending is already 1.
  - Reset value 0.
  - Clears on an accepted cfg write with cfg_idx==7.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then hold frame=0 -> busy=0, cfg_ready=1. Pixel (0,0) gives data=24'h012345. Pixel (150,150) gives 24'hFF0000. Pixel (799,599) gives 24'h000000.
- Single frame pulse at cycle t -> busy high t+1..t+4. Sprite 0 moves to (1,1) at t+1, sprite 3 moves to (301,301) at t+4. cfg_ready is low during t+1..t+4.
- Write idx0 x=750 y=20, then 1 frame -> stored x=700 (clamped). After the pass, dir_x is flipped, x stays 700, y=21, and colour index goes 0->1, so pixel (700,21) gives 24'hFF0000.
- Write idx0 x=700 y=500, then 1 frame -> both axes flip and colour advances exactly once, 0->1.
- Three frame pulses during one pass -> exactly one extra pass, busy continuous for 8 cycles. With SPRITE_OVERRUN_CNT_EN, overrun_cnt=2.
- Overlap of sprites 1 and 2 at pixel (250,250) -> data shows sprite 1's colour. Assert reset mid-pass -> positions return to their reset values and busy=0 immediately.
